// File: rtl/gray_to_rgb565_buffer_pkg.sv
// gray_to_rgb565_buffer_pkg: opcodes, FIFO geometry and status-word layout shared by the
// buffer and its users.
package gray_to_rgb565_buffer_pkg;
   typedef enum logic [1:0] {
      OP_PUSH   = 2'd0,
      OP_POP    = 2'd1,
      OP_STATUS = 2'd2,
      OP_CLEAR  = 2'd3
   } op_e;
   localparam int FIFO_DEPTH     = 16;
   localparam int PTR_W          = $clog2(FIFO_DEPTH);
   localparam int CNT_W          = PTR_W + 1;
   localparam int PUSH_BYTES     = 4;
   localparam int POP_PIXELS     = 2;
   localparam int PUSH_MAX_CNT   = FIFO_DEPTH - PUSH_BYTES;
   localparam int STATUS_OVF_BIT = 8;
   localparam int STATUS_UNF_BIT = 9;
   function automatic logic [31:0] status_word(input logic unf, input logic ovf,
                                               input logic [CNT_W-1:0] cnt);
      logic [31:0] w;
      w                 = '0;
      w[STATUS_UNF_BIT] = unf;
      w[STATUS_OVF_BIT] = ovf;
      w[CNT_W-1:0]      = cnt;
      return w;
   endfunction
endpackage

// File: rtl/gray_to_rgb565_buffer_gray8.sv
// gray8_to_rgb565: replicates an 8-bit gray level into RGB565 by pure bit selection.
module gray8_to_rgb565 (
   input  logic [7:0]  gray,
   output logic [15:0] rgb
);
   assign rgb = {gray[7:3], gray[7:2], gray[7:3]};
endmodule

// File: rtl/gray_to_rgb565_buffer.sv
// gray_to_rgb565_buffer: custom-instruction gray-pixel FIFO; PUSH packs four gray bytes,
// POP returns two RGB565 pixels, with sticky over/underflow flags and fixed latency 1.
module gray_to_rgb565_buffer
   import gray_to_rgb565_buffer_pkg::*;
#(
   parameter logic [7:0] customInstructionID = 8'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   input  logic [7:0]  isId,
   output logic        done,
   output logic [31:0] result
);
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;
   logic [31:0]      result_q, result_d;
   logic [15:0]      rgb0, rgb1;
   logic             accept;
   op_e              op;
   logic             unused_b;

   assign unused_b = ^valueB[31:2];
   assign accept   = start && (isId == customInstructionID);
   assign op       = op_e'(valueB[1:0]);

   gray8_to_rgb565 u_rgb0 (.gray(mem_q[rd_q]),                .rgb(rgb0));
   gray8_to_rgb565 u_rgb1 (.gray(mem_q[rd_q + PTR_W'(1)]),    .rgb(rgb1));

   always_comb begin
      mem_d    = mem_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      done_d   = accept;
      result_d = '0;
      if (accept) begin
         unique case (op)
            OP_PUSH: begin
               if (cnt_q <= CNT_W'(PUSH_MAX_CNT)) begin
                  for (int k = 0; k < PUSH_BYTES; k++)
                     mem_d[wr_q + PTR_W'(k)] = valueA[8*k +: 8];
                  wr_d  = wr_q + PTR_W'(PUSH_BYTES);
                  cnt_d = cnt_q + CNT_W'(PUSH_BYTES);
               end else begin
                  ovf_d    = 1'b1;
                  result_d = 32'h1;
               end
            end
            OP_POP: begin
               if (cnt_q >= CNT_W'(POP_PIXELS)) begin
                  rd_d     = rd_q + PTR_W'(POP_PIXELS);
                  cnt_d    = cnt_q - CNT_W'(POP_PIXELS);
                  result_d = {rgb1, rgb0};
               end else begin
                  unf_d = 1'b1;
               end
            end
            OP_STATUS: begin
               // report flags as they were, then clear them on this same edge
               result_d = status_word(unf_q, ovf_q, cnt_q);
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
            end
            OP_CLEAR: begin
               wr_d  = '0;
               rd_d  = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
               unf_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // pixel storage is not reset; pointers and count define what is valid
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign done   = done_q;
   assign result = result_q;
endmodule

// File: tb/tb_gray_to_rgb565_buffer.sv
// tb_gray_to_rgb565_buffer: directed and randomized instruction streams checked against a
// queue-based reference model of the pixel buffer.
module tb_gray_to_rgb565_buffer;
   localparam logic [7:0] ID = 8'h5A;
   localparam int PUSH = 0, POP = 1, STATUS = 2, CLEAR = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] valueA = '0;
   logic [31:0] valueB = '0;
   logic [7:0]  isId = '0;
   logic        done;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  fifo [$];
   bit          ovf = 0;
   bit          unf = 0;
   logic [31:0] r;

   gray_to_rgb565_buffer #(.customInstructionID(ID)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .valueA(valueA),
      .valueB(valueB),
      .isId  (isId),
      .done  (done),
      .result(result)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rgb(input logic [7:0] g);
      int red, grn;
      red = int'(g) / 8;
      grn = int'(g) / 4;
      return 16'(red * 2048 + grn * 32 + red);
   endfunction

   function automatic logic [31:0] model(input int op, input logic [31:0] a, input bit mine);
      logic [7:0]  p0, p1;
      logic [31:0] w;
      if (!mine) return 32'h0;
      case (op)
         PUSH: begin
            if (fifo.size() > 12) begin
               ovf = 1;
               return 32'h1;
            end
            for (int k = 0; k < 4; k++) fifo.push_back(a[8*k +: 8]);
            return 32'h0;
         end
         POP: begin
            if (fifo.size() < 2) begin
               unf = 1;
               return 32'h0;
            end
            p0 = fifo.pop_front();
            p1 = fifo.pop_front();
            return {rgb(p1), rgb(p0)};
         end
         STATUS: begin
            w = 32'(unf) * 512 + 32'(ovf) * 256 + 32'(fifo.size());
            ovf = 0;
            unf = 0;
            return w;
         end
         default: begin
            fifo.delete();
            ovf = 0;
            unf = 0;
            return 32'h0;
         end
      endcase
   endfunction

   // called on a falling edge; leaves on the next falling edge so calls chain back-to-back
   task automatic exec(input string tag, input int op, input logic [31:0] a, input bit mine,
                       output logic [31:0] got);
      logic [31:0] exp;
      logic [31:0] b;
      b      = $urandom();
      b[1:0] = 2'(op);
      start  = 1'b1;
      valueA = a;
      valueB = b;
      isId   = mine ? ID : (ID ^ 8'($urandom_range(1, 255)));
      exp    = model(op, a, mine);
      @(negedge clock);
      start = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'(mine));
      chk(tag, result, exp);
      got = result;
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_result", result, 32'h0);
      reset = 1'b1;

      exec("status_after_rst", STATUS, 32'h0, 1, r);
      chk("req027", r, 32'h0);

      exec("push_a", PUSH, 32'hFF80_4000, 1, r);
      exec("pop_a", POP, 32'h0, 1, r);
      chk("req028_pop1", r, 32'h4208_0000);
      exec("pop_b", POP, 32'h0, 1, r);
      chk("req028_pop2", r, 32'hFFFF_8410);
      exec("status_a", STATUS, 32'h0, 1, r);
      chk("req028_status", r, 32'h0);

      for (int i = 0; i < 5; i++) exec("push_fill", PUSH, $urandom(), 1, r);
      chk("req029_push5", r, 32'h1);
      exec("status_ovf", STATUS, 32'h0, 1, r);
      chk("req029_status1", r, 32'h0000_0110);
      exec("status_ovf2", STATUS, 32'h0, 1, r);
      chk("req029_status2", r, 32'h0000_0010);

      exec("clear_a", CLEAR, 32'h0, 1, r);
      exec("pop_empty", POP, 32'h0, 1, r);
      chk("req030_pop", r, 32'h0);
      exec("status_unf", STATUS, 32'h0, 1, r);
      chk("req030_status", r, 32'h0000_0200);
      for (int i = 0; i < 3; i++) exec("push_pre_clr", PUSH, $urandom(), 1, r);
      exec("clear_b", CLEAR, 32'h0, 1, r);
      exec("status_clr", STATUS, 32'h0, 1, r);
      chk("req030_clear", r, 32'h0);

      exec("foreign_push", PUSH, 32'hDEAD_BEEF, 0, r);
      exec("status_foreign", STATUS, 32'h0, 1, r);
      chk("foreign_no_effect", r, 32'h0);

      for (int i = 0; i < 60; i++) begin
         int sel, op;
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clock);
            chk("idle_done", 32'(done), 32'h0);
         end
         sel = $urandom_range(0, 9);
         op  = (sel < 5) ? PUSH : (sel < 9) ? POP : STATUS;
         exec("rand", op, $urandom(), $urandom_range(0, 4) != 0, r);
      end

      start  = 1'b1;
      valueA = 32'h1234_5678;
      valueB = 32'(PUSH);
      isId   = ID;
      @(posedge clock);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_result", result, 32'h0);
      @(negedge clock);
      chk("abort_done2", 32'(done), 32'h0);
      reset = 1'b1;
      fifo.delete();
      ovf = 0;
      unf = 0;
      exec("status_abort", STATUS, 32'h0, 1, r);
      chk("req032_status", r, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
